crypto_multikey: RTL and testbench

Parametrised successor to the single-key datapath cipher. It sits in the user datapath between the input arbiter and the output port lookup on the 64-bit packet bus. It XOR-encrypts packet payload with up to `NUM_KEYS` 64-bit keys, applied as either one fixed key or a per-word rotating key schedule. It adds a register-ring slave for mode, keys and a packet counter.

---
 rtl/crypto_multikey_if.sv | 46 ++++
 rtl/crypto_multikey.sv | 200 ++++++++++++++++++++
 tb/tb_crypto_multikey.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crypto_multikey_if.sv
// Packet bus and register ring bundle for crypto_multikey.
// The slave modport is the cipher's view; the master modport is the view of
// whatever drives the upstream bus and register ring and sinks the output.
interface crypto_multikey_if #(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH   = 2,
  parameter int UDP_REG_ADDR_WIDTH  = 23,
  parameter int CPCI_NF2_DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]          in_data;
  logic [CTRL_WIDTH-1:0]          in_ctrl;
  logic                           in_wr;
  logic                           in_rdy;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [CTRL_WIDTH-1:0]          out_ctrl;
  logic                           out_wr;
  logic                           out_rdy;

  logic                           reg_req_in;
  logic                           reg_ack_in;
  logic                           reg_rd_wr_L_in;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in;
  logic                           reg_req_out;
  logic                           reg_ack_out;
  logic                           reg_rd_wr_L_out;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out;

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr,
    input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
    output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr,
    output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
    input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );
endinterface

// File: rtl/crypto_multikey.sv
// XOR payload cipher with up to NUM_KEYS 64-bit keys (single or rotating),
// plus a register-ring slave for mode, keys and a packet counter.
//
// state | meaning
// HDR   | module headers (ctrl != 0) pass; first ctrl == 0 word starts the packet
// SKIP  | protocol header words pass in clear until SKIP_WORDS data words are seen
// PAY   | payload words XORed with the per-packet key schedule
module crypto_multikey #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int          UDP_REG_SRC_WIDTH = 2,
  parameter int          NUM_KEYS          = 4,
  parameter int          SKIP_WORDS        = 6,
  parameter logic [22:0] REG_BLOCK_TAG     = 23'h000200
) (
  input logic              clk,
  input logic              reset,
  crypto_multikey_if.slave bus
);

  typedef enum logic [1:0] {HDR, SKIP, PAY} state_t;

  localparam int IW  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int SKW = $clog2(SKIP_WORDS + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_KEYS - 1);

  state_t                  state_q, state_d;
  logic [SKW-1:0]          skip_cnt_q, skip_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [1:0]              mode_q, mode_sh_q;
  logic [63:0]             key_q    [NUM_KEYS];
  logic [63:0]             key_sh_q [NUM_KEYS];
  logic [31:0]             pkt_cnt_q;
  logic [DATA_WIDTH-1:0]   data_d, out_data_q;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q;
  logic                    out_wr_q;
  logic                    accept, ctrl_nz, load_shadow, pkt_inc;

  logic                    addressed, reg_wr;
  logic [3:0]              off;
  logic [31:0]             rd_val;
  logic                    req_out_q, ack_out_q, rdwr_out_q;
  logic [22:0]             addr_out_q;
  logic [31:0]             data_out_q;
  logic [UDP_REG_SRC_WIDTH-1:0] src_out_q;

  function automatic logic [DATA_WIDTH-1:0] crypt(input logic [1:0] m,
                                                  input logic [63:0] k,
                                                  input logic [DATA_WIDTH-1:0] d);
    return (m == 2'd1 || m == 2'd2) ? (d ^ k) : d;
  endfunction

  assign accept  = bus.in_wr && bus.out_rdy;
  assign ctrl_nz = (bus.in_ctrl != '0);
  assign bus.in_rdy = bus.out_rdy;

  // Packet FSM next state and per-word datapath transform.
  // skip_cnt counts clear data words seen so far, including the first one.
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    idx_d       = idx_q;
    data_d      = bus.in_data;
    load_shadow = 1'b0;
    pkt_inc     = 1'b0;
    if (accept) begin
      case (state_q)
        HDR: begin
          if (!ctrl_nz) begin
            load_shadow = 1'b1;
            skip_cnt_d  = '0;
            idx_d       = '0;
            if (SKIP_WORDS == 0) begin
              // No clear words: this word is already payload, keyed from live regs.
              data_d  = crypt(mode_q, key_q[0], bus.in_data);
              if (mode_q == 2'd2) idx_d = (LAST_IDX == '0) ? '0 : IW'(1);
              state_d = PAY;
            end else begin
              skip_cnt_d = SKW'(1);
              state_d    = (SKIP_WORDS == 1) ? PAY : SKIP;
            end
          end
        end
        SKIP: begin
          if (ctrl_nz) begin
            state_d = HDR;
            pkt_inc = 1'b1;
          end else begin
            skip_cnt_d = skip_cnt_q + SKW'(1);
            if (skip_cnt_q + SKW'(1) == SKW'(SKIP_WORDS)) state_d = PAY;
          end
        end
        PAY: begin
          data_d = crypt(mode_sh_q, key_sh_q[idx_q], bus.in_data);
          if (mode_sh_q == 2'd2) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
          if (ctrl_nz) begin
            state_d = HDR;
            pkt_inc = 1'b1;
          end
        end
        default: state_d = HDR;
      endcase
    end
  end

  // FSM state, counters and registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HDR;
      skip_cnt_q <= '0;
      idx_q      <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      idx_q      <= idx_d;
      out_wr_q   <= accept;
      if (accept) begin
        out_data_q <= data_d;
        out_ctrl_q <= bus.in_ctrl;
      end
    end
  end

  // Per-packet snapshot so register writes only affect the next packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_sh_q <= 2'd0;
      for (int k = 0; k < NUM_KEYS; k++) key_sh_q[k] <= '0;
    end else if (load_shadow) begin
      mode_sh_q <= mode_q;
      for (int k = 0; k < NUM_KEYS; k++) key_sh_q[k] <= key_q[k];
    end
  end

  assign addressed = bus.reg_req_in && !bus.reg_ack_in &&
                     (bus.reg_addr_in[22:4] == REG_BLOCK_TAG[22:4]);
  assign reg_wr    = addressed && !bus.reg_rd_wr_L_in;
  assign off       = bus.reg_addr_in[3:0];

  // Read mux; unmapped offsets return a recognisable marker.
  always_comb begin
    rd_val = 32'hDEADBEEF;
    if (off == 4'd0)      rd_val = {30'd0, mode_q};
    else if (off == 4'd1) rd_val = pkt_cnt_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (off == 4'(2 + 2 * k)) rd_val = key_q[k][31:0];
      if (off == 4'(3 + 2 * k)) rd_val = key_q[k][63:32];
    end
  end

  // Configuration registers and packet counter (a write-clear beats an increment).
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 2'd0;
      pkt_cnt_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= '0;
    end else begin
      if (reg_wr && off == 4'd0) mode_q <= bus.reg_data_in[1:0];
      if (reg_wr && off == 4'd1)            pkt_cnt_q <= '0;
      else if (pkt_inc && pkt_cnt_q != '1)  pkt_cnt_q <= pkt_cnt_q + 32'd1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (reg_wr && off == 4'(2 + 2 * k)) key_q[k][31:0]  <= bus.reg_data_in;
        if (reg_wr && off == 4'(3 + 2 * k)) key_q[k][63:32] <= bus.reg_data_in;
      end
    end
  end

  // Register ring stage: pass through, claim addressed requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_out_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      rdwr_out_q <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      src_out_q  <= '0;
    end else begin
      req_out_q  <= bus.reg_req_in;
      ack_out_q  <= bus.reg_ack_in || addressed;
      rdwr_out_q <= bus.reg_rd_wr_L_in;
      addr_out_q <= bus.reg_addr_in;
      data_out_q <= (addressed && bus.reg_rd_wr_L_in) ? rd_val : bus.reg_data_in;
      src_out_q  <= bus.reg_src_in;
    end
  end

  assign bus.out_wr          = out_wr_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_ctrl        = out_ctrl_q;
  assign bus.reg_req_out     = req_out_q;
  assign bus.reg_ack_out     = ack_out_q;
  assign bus.reg_rd_wr_L_out = rdwr_out_q;
  assign bus.reg_addr_out    = addr_out_q;
  assign bus.reg_data_out    = data_out_q;
  assign bus.reg_src_out     = src_out_q;

endmodule

// File: tb/tb_crypto_multikey.sv
// Bench for crypto_multikey: register-ring vector table, directed packet
// sequences and randomized packets against a packet-level reference model.
module tb_crypto_multikey;
  localparam int          NK   = 4;
  localparam int          SKIP = 6;
  localparam logic [22:0] TAG  = 23'h000200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crypto_multikey_if bus ();
  crypto_multikey #(.NUM_KEYS(NK), .SKIP_WORDS(SKIP), .REG_BLOCK_TAG(TAG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Configuration as last written by the bench.
  logic [1:0]  m_mode;
  logic [63:0] m_key [NK];
  logic [31:0] m_cnt;

  logic [63:0] pkt_d[$], exp_d[$], got_d[$];
  logic [7:0]  pkt_c[$], exp_c[$], got_c[$];
  logic        acc_hist = 1'b0;

  typedef struct {
    logic        req;
    logic        ack;
    logic        rdwr;
    logic [22:0] addr;
    logic [31:0] data;
    logic [1:0]  src;
    logic        exp_ack;
    logic [31:0] exp_data;
  } ring_vec_t;
  ring_vec_t tbl [13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] ra(input logic [3:0] o);
    return {TAG[22:4], o};
  endfunction

  // Output monitor: every accepted word appears exactly once, one cycle later.
  always @(posedge clk) acc_hist <= !reset && bus.in_wr && bus.in_rdy;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.in_rdy !== bus.out_rdy) check("in_rdy_follows_out_rdy", bus.in_rdy, bus.out_rdy);
      if (bus.out_wr || acc_hist) check("out_wr_latency", bus.out_wr, acc_hist);
      if (bus.out_wr) begin
        got_d.push_back(bus.out_data);
        got_c.push_back(bus.out_ctrl);
      end
    end
  end

  task automatic ring_idle();
    bus.reg_req_in     = 1'b0;
    bus.reg_ack_in     = 1'b0;
    bus.reg_rd_wr_L_in = 1'b0;
    bus.reg_addr_in    = '0;
    bus.reg_data_in    = '0;
    bus.reg_src_in     = '0;
  endtask

  task automatic reg_write(input logic [3:0] o, input logic [31:0] v);
    bus.reg_req_in     = 1'b1;
    bus.reg_ack_in     = 1'b0;
    bus.reg_rd_wr_L_in = 1'b0;
    bus.reg_addr_in    = ra(o);
    bus.reg_data_in    = v;
    bus.reg_src_in     = 2'd1;
    tick();
    check("reg_write_ack", bus.reg_ack_out, 1'b1);
    ring_idle();
    if (o == 4'd0) m_mode = v[1:0];
    if (o == 4'd1) m_cnt = '0;
    for (int k = 0; k < NK; k++) begin
      if (o == 4'(2 + 2 * k)) m_key[k][31:0]  = v;
      if (o == 4'(3 + 2 * k)) m_key[k][63:32] = v;
    end
  endtask

  task automatic reg_read(input logic [3:0] o, input logic [31:0] exp, input string name);
    bus.reg_req_in     = 1'b1;
    bus.reg_ack_in     = 1'b0;
    bus.reg_rd_wr_L_in = 1'b1;
    bus.reg_addr_in    = ra(o);
    bus.reg_data_in    = $urandom;
    bus.reg_src_in     = 2'($urandom_range(0, 3));
    tick();
    check(name, {bus.reg_ack_out, bus.reg_data_out}, {1'b1, exp});
    ring_idle();
  endtask

  task automatic build_pkt(input int nhdr, input int ndata);
    pkt_d.delete();
    pkt_c.delete();
    for (int i = 0; i < nhdr; i++) begin
      pkt_d.push_back({$urandom, $urandom});
      pkt_c.push_back(8'($urandom_range(1, 255)));
    end
    for (int i = 0; i < ndata - 1; i++) begin
      pkt_d.push_back({$urandom, $urandom});
      pkt_c.push_back(8'h00);
    end
    pkt_d.push_back({$urandom, $urandom});
    pkt_c.push_back(8'h80 >> $urandom_range(0, 7));
  endtask

  // Reference: data word n (1-based) is clear for n <= SKIP, otherwise
  // payload position p = n-SKIP-1 uses key 0 (single) or key p mod NK (rotating).
  task automatic model_pkt();
    int n = 0;
    for (int i = 0; i < pkt_d.size(); i++) begin
      logic [63:0] d;
      d = pkt_d[i];
      if (pkt_c[i] == 8'h00 || n > 0) begin
        n++;
        if (n > SKIP && m_mode == 2'd1) d = d ^ m_key[0];
        if (n > SKIP && m_mode == 2'd2) d = d ^ m_key[(n - SKIP - 1) % NK];
        if (pkt_c[i] != 8'h00) begin
          n = 0;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
      end
      exp_d.push_back(d);
      exp_c.push_back(pkt_c[i]);
    end
  endtask

  task automatic send_pkt(input bit bp);
    model_pkt();
    for (int i = 0; i < pkt_d.size(); i++) begin
      if (bp) begin
        int w = 0;
        while ($urandom_range(0, 2) == 0 && w < 8) begin
          bus.out_rdy = 1'b0;
          bus.in_wr   = 1'b0;
          tick();
          w++;
        end
      end
      bus.out_rdy = 1'b1;
      bus.in_wr   = 1'b1;
      bus.in_data = pkt_d[i];
      bus.in_ctrl = pkt_c[i];
      tick();
    end
    bus.in_wr   = 1'b0;
    bus.out_rdy = 1'b1;
  endtask

  task automatic compare_out(input string name);
    int n;
    repeat (2) tick();
    check({name, "_count"}, got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_word%0d", name, i), {got_c[i], got_d[i]}, {exp_c[i], exp_d[i]});
    got_d.delete(); got_c.delete(); exp_d.delete(); exp_c.delete();
  endtask

  initial begin
    m_mode = '0;
    m_cnt  = '0;
    for (int k = 0; k < NK; k++) m_key[k] = '0;

    // Reset with busy inputs: all outputs must be held at zero.
    reset              = 1'b1;
    bus.out_rdy        = 1'b1;
    bus.in_wr          = 1'b1;
    bus.in_data        = 64'h0123_4567_89AB_CDEF;
    bus.in_ctrl        = 8'h00;
    bus.reg_req_in     = 1'b1;
    bus.reg_ack_in     = 1'b0;
    bus.reg_rd_wr_L_in = 1'b1;
    bus.reg_addr_in    = ra(4'd15);
    bus.reg_data_in    = 32'h1234_5678;
    bus.reg_src_in     = 2'd3;
    repeat (3) tick();
    check("reset_packet_out", {bus.out_wr, bus.out_ctrl, bus.out_data}, '0);
    check("reset_ring_out", {bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out,
                             bus.reg_addr_out, bus.reg_data_out, bus.reg_src_out}, '0);
    bus.in_wr = 1'b0;
    ring_idle();
    reset = 1'b0;
    tick();

    // Register ring vectors, applied back to back.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, ra(4'd0),   32'd2,          2'd1, 1'b1, 32'd2};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, ra(4'd0),   32'h1111,       2'd2, 1'b1, 32'd2};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, ra(4'd5),   32'h1234_5678,  2'd3, 1'b1, 32'h1234_5678};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, ra(4'd5),   32'h0,          2'd0, 1'b1, 32'h1234_5678};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, ra(4'd15),  32'h5,          2'd1, 1'b1, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, ra(4'd10),  32'h6,          2'd2, 1'b1, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, ra(4'd12),  32'h55,         2'd0, 1'b1, 32'h55};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, ra(4'd12),  32'h7,          2'd3, 1'b1, 32'hDEAD_BEEF};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 23'h000301, 32'hCAFE,       2'd1, 1'b0, 32'hCAFE};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, ra(4'd0),   32'h777,        2'd2, 1'b1, 32'h777};
    tbl[10] = '{1'b0, 1'b0, 1'b1, ra(4'd1),   32'h99,         2'd1, 1'b0, 32'h99};
    tbl[11] = '{1'b1, 1'b0, 1'b1, ra(4'd1),   32'hABCD,       2'd0, 1'b1, 32'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, ra(4'd0),   32'd0,          2'd2, 1'b1, 32'd0};
    for (int i = 0; i < 13; i++) begin
      bus.reg_req_in     = tbl[i].req;
      bus.reg_ack_in     = tbl[i].ack;
      bus.reg_rd_wr_L_in = tbl[i].rdwr;
      bus.reg_addr_in    = tbl[i].addr;
      bus.reg_data_in    = tbl[i].data;
      bus.reg_src_in     = tbl[i].src;
      tick();
      check($sformatf("ring_vec%0d", i),
            {bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out,
             bus.reg_addr_out, bus.reg_data_out, bus.reg_src_out},
            {tbl[i].req, tbl[i].exp_ack, tbl[i].rdwr, tbl[i].addr, tbl[i].exp_data, tbl[i].src});
    end
    ring_idle();
    m_key[1][63:32] = 32'h1234_5678;
    tick();

    // Bypass.
    reg_write(4'd0, 32'd0);
    build_pkt(1, 10);
    send_pkt(1'b0);
    compare_out("bypass");
    reg_read(4'd1, 32'd1, "pkt_cnt_after_bypass");

    // Single key.
    reg_write(4'd2, 32'hFFFF_1234);
    reg_write(4'd3, 32'hA5A5_0000);
    reg_write(4'd0, 32'd1);
    build_pkt(1, 10);
    send_pkt(1'b0);
    compare_out("single");

    // Rotating keys 1<<k.
    for (int k = 0; k < NK; k++) begin
      reg_write(4'(2 + 2 * k), 32'd1 << k);
      reg_write(4'(3 + 2 * k), 32'd0);
    end
    reg_write(4'd0, 32'd2);
    build_pkt(1, 12);
    send_pkt(1'b0);
    compare_out("rotating");

    // Mode write mid-packet applies only to the following packet.
    build_pkt(1, 12);
    fork
      send_pkt(1'b0);
      begin
        repeat (5) tick();
        reg_write(4'd0, 32'd0);
      end
    join
    compare_out("midwrite_inflight");
    build_pkt(1, 12);
    send_pkt(1'b0);
    compare_out("midwrite_next");

    // Short packet under backpressure, rotating mode.
    reg_write(4'd0, 32'd2);
    build_pkt(1, 4);
    send_pkt(1'b1);
    compare_out("short");
    reg_read(4'd1, m_cnt, "pkt_cnt_after_short");

    // Counter clear lands on the end-of-packet cycle: clear wins.
    build_pkt(1, 8);
    fork
      send_pkt(1'b0);
      begin
        repeat (8) tick();
        reg_write(4'd1, 32'd0);
      end
    join
    compare_out("clear_on_eop");
    reg_read(4'd1, 32'd0, "pkt_cnt_clear_wins");

    // Randomized packets with backpressure and reconfiguration between packets.
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 1) == 1) reg_write(4'd0, 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        for (int o = 2; o < 2 + 2 * NK; o++) reg_write(4'(o), $urandom);
      end
      build_pkt($urandom_range(0, 2), $urandom_range(2, 20));
      send_pkt(1'b1);
      compare_out($sformatf("rand%0d", p));
    end
    reg_read(4'd1, m_cnt, "pkt_cnt_random");
    for (int k = 0; k < NK; k++) reg_read(4'(3 + 2 * k), m_key[k][63:32], "key_hi_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
